core_sys_to_hps: RTL and testbench

//  Avalon-MM slave input PIO carrying FPGA-side status (buttons, switches, sensor flags) to the HPS.

---
 rtl/core_sys_to_hps.sv | 114 +++++++++++
 tb/tb_core_sys_to_hps.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/core_sys_to_hps.sv
// Avalon-MM s1 input PIO: synchronises FPGA-side status inputs, captures per-bit
// edges into sticky flags, and raises a maskable level interrupt toward the HPS.
module core_sys_to_hps #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_EDGESEL = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_edgesel;
  logic [WIDTH-1:0]                  r_irqmask;
  logic [WIDTH-1:0]                  r_edgecap;
  logic                              r_irq;

  logic             w_wr;
  logic             w_wr_edgesel;
  logic             w_wr_irqmask;
  logic             w_wr_edgecap;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_edgecap_nxt;

  assign w_wr         = chipselect & ~write_n;
  assign w_wr_edgesel = w_wr & (address == ADDR_EDGESEL);
  assign w_wr_irqmask = w_wr & (address == ADDR_IRQMASK);
  assign w_wr_edgecap = w_wr & (address == ADDR_EDGECAP);
  assign w_wdata      = writedata[WIDTH-1:0];

  // Stage 0 is the metastability catcher; only the last stage is ever used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_sync_q;
    end
  end

  assign w_rise = w_sync_q & ~r_prev;
  assign w_fall = ~w_sync_q & r_prev;
  assign w_hit  = (r_edgesel & w_fall) | (~r_edgesel & w_rise);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgesel <= '0;
      r_irqmask <= '0;
    end else begin
      if (w_wr_edgesel) r_edgesel <= w_wdata;
      if (w_wr_irqmask) r_irqmask <= w_wdata;
    end
  end

  // Set wins over clear so an edge arriving during a W1C is never lost.
  assign w_clr         = w_wr_edgecap ? w_wdata : '0;
  assign w_edgecap_nxt = (r_edgecap & ~w_clr) | w_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= w_edgecap_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  assign irq = r_irq;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = w_sync_q;
      ADDR_EDGESEL: readdata[WIDTH-1:0] = r_edgesel;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_core_sys_to_hps.sv
// Directed bench for core_sys_to_hps: expected values queued as stimulus is
// applied, then popped and compared against DUT observations.
module tb_core_sys_to_hps;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  core_sys_to_hps #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    address = a;
    #1;
    expect_val(e);
    check(tag, readdata);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    expect_val({31'b0, e});
    check(tag, {31'b0, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 32'hFFFF_FFFF;

    // reset held with inputs high
    tick(3);
    rd("rst_data", 2'd0, 32'h0);
    rd("rst_edgesel", 2'd1, 32'h0);
    rd("rst_irqmask", 2'd2, 32'h0);
    rd("rst_edgecap", 2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // release: DATA stays 0 until the chain fills
    reset_n = 1'b1;
    tick(1);
    rd("fill_1clk", 2'd0, 32'h0);
    tick(1);
    rd("fill_2clk", 2'd0, 32'hFFFF_FFFF);
    tick(1);
    rd("fill_cap", 2'd3, 32'hFFFF_FFFF);
    chk_irq("fill_irq_masked", 1'b0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("w1c_all", 2'd3, 32'h0);

    // data path latency
    in_port = 32'hA5A5_0F0F;
    tick(1);
    rd("data_1clk_old", 2'd0, 32'hFFFF_FFFF);
    tick(2);
    rd("data_3clk", 2'd0, 32'hA5A5_0F0F);
    rd("data_no_rise_cap", 2'd3, 32'h0);
    in_port = 32'h0;
    tick(4);
    rd("fall_ignored", 2'd3, 32'h0);

    // rising capture + irq
    wr(2'd2, 32'h1);
    rd("irqmask_rb", 2'd2, 32'h1);
    in_port = 32'h1;
    tick(2);
    rd("rise_clk2", 2'd3, 32'h0);
    tick(1);
    rd("rise_clk3", 2'd3, 32'h1);
    chk_irq("irq_clk3", 1'b0);
    tick(1);
    chk_irq("irq_clk4", 1'b1);
    wr(2'd3, 32'h1);
    rd("rise_cleared", 2'd3, 32'h0);
    chk_irq("irq_lag", 1'b1);
    tick(1);
    chk_irq("irq_dropped", 1'b0);

    // falling select on bit 1
    wr(2'd1, 32'h2);
    wr(2'd2, 32'h0);
    rd("edgesel_rb", 2'd1, 32'h2);
    in_port = 32'h3;
    tick(4);
    rd("fall_sel_rise", 2'd3, 32'h0);
    in_port = 32'h1;
    tick(3);
    rd("fall_sel_fall", 2'd3, 32'h2);
    tick(1);
    chk_irq("fall_irq_masked", 1'b0);
    wr(2'd2, 32'h2);
    chk_irq("mask_irq_lag", 1'b0);
    tick(1);
    chk_irq("mask_irq_on", 1'b1);
    wr(2'd2, 32'h0);
    tick(1);
    chk_irq("mask_irq_off", 1'b0);
    wr(2'd3, 32'h2);
    wr(2'd1, 32'h0);
    tick(3);
    rd("no_retro_edge", 2'd3, 32'h0);

    // set/clear collision on bit 0
    in_port = 32'h0;
    tick(4);
    rd("pre_collide", 2'd3, 32'h0);
    in_port = 32'h1;
    tick(2);
    wr(2'd3, 32'h1);
    rd("collide_set_wins", 2'd3, 32'h1);
    wr(2'd3, 32'h0);
    rd("w1c_zero", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    rd("w1c_bit0", 2'd3, 32'h0);

    // async reset mid-capture
    in_port = 32'h0;
    tick(4);
    wr(2'd2, 32'hF);
    in_port = 32'hF;
    tick(4);
    rd("pre_rst_cap", 2'd3, 32'hF);
    chk_irq("pre_rst_irq", 1'b1);
    reset_n = 1'b0;
    #1;
    rd("async_rst_cap", 2'd3, 32'h0);
    chk_irq("async_rst_irq", 1'b0);
    rd("async_rst_mask", 2'd2, 32'h0);
    tick(3);
    rd("rst_hold_cap", 2'd3, 32'h0);
    chk_irq("rst_hold_irq", 1'b0);
    reset_n = 1'b1;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
